ss_rx_checker: RTL and testbench
================================

# ss_rx_checker

Terminal slave endpoint for the ss streaming protocol. It accepts packets from any ss master, drives `ready` with an optional pseudo-random backpressure pattern, checks every protocol rule, and emits one status record per packet: byte length, checksum, user and error flags. It sits at the receiving end of ss links in test harnesses and at sink points in packet-processing designs.

## Interface
Parameters:
- NUM_BYTES, 4, bytes per beat; data width is NUM_BYTES*8.
- USER_BITS, 1, width of the per-packet sideband field.
- MAX_PKT_BYTES, 2048, largest legal packet in bytes.
- LEN_W, 16, width of the length output.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  master attempting a transfer.
- s_ready  out  1  this block accepts a beat this cycle.
- s_data  in  NUM_BYTES*8  beat data, big endian (first byte in the MSBs).
- s_keep  in  NUM_BYTES  valid bytes on the last beat; MSB corresponds to the first byte.
- s_last  in  1  last beat of the packet.
- s_user  in  USER_BITS  packet sideband field.
- bp_en  in  1  1 enables LFSR-driven backpressure.
- bp_seed  in  16  LFSR seed, loaded during reset.
- stat_valid  out  1  one-cycle pulse announcing a new status record.
- stat_len  out  LEN_W  packet byte count, saturating.
- stat_csum  out  16  sum of all kept bytes, mod 2^16.
- stat_user  out  USER_BITS  user value captured on the first beat.
- stat_err  out  4  error flags, bit positions listed under Operation.
- pkt_count  out  32  packets completed since reset; wraps.

## Operation
- A beat is accepted when s_valid and s_ready are both 1 in the same cycle.
- **States:**
  - IDLE: no packet is open. An accepted beat with s_last=0 moves to BODY. An accepted beat with s_last=1 completes a single-beat packet and stays in IDLE.
  - BODY: a packet is open. An accepted beat with s_last=1 completes the packet and moves to IDLE.
- **First beat** (accepted in IDLE): capture s_user; clear the length, checksum and error accumulators.
- **Length:**
  - Non-last beat adds NUM_BYTES.
  - Last beat adds popcount(s_keep).
  - Saturates at 2^LEN_W-1.
- **Checksum:** adds every byte whose keep bit is 1. All bytes of non-last beats count as kept.
- **Error bits:** sticky for the open packet; they are reported and then cleared at packet completion.
  - Bit 0, VALID_DROP: in the previous cycle s_valid=1 and s_ready=0, and s_valid=0 this cycle.
  - Bit 1, UNSTABLE: during a stall (previous cycle s_valid=1, s_ready=0), s_data, s_keep, s_last or s_user differs from its previous-cycle value. Also set when s_user on a later beat differs from the value captured on the first beat.
  - Bit 2, BAD_KEEP: on a non-last beat, s_keep is not all ones. On a last beat, s_keep is zero or its ones are not contiguous from the MSB.
  - Bit 3, OVERLEN: the accumulated length exceeds MAX_PKT_BYTES.
- **Violations outside a packet:** a stall violation seen while in IDLE is attached to the next packet.
- **Backpressure:**
  - bp_en=0: s_ready is 1 in every cycle after reset.
  - bp_en=1: s_ready equals LFSR bit 0.
  - LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11, advances every non-reset cycle.
  - A seed of 0 is replaced by 16'hACE1.
- **Completion:** the accepted last beat updates every stat_* output and increments pkt_count.

## Timing
- **Reset values:**
  - s_ready=0, stat_valid=0, stat_len=0, stat_csum=0, stat_user=0, stat_err=0, pkt_count=0.
  - FSM in IDLE; LFSR loaded with bp_seed.
- s_ready reaches its first non-reset value in the cycle after rst deasserts.
- **Status latency:** stat_valid is high exactly 1 cycle after the cycle in which the last beat is accepted. In that same cycle stat_len, stat_csum, stat_user, stat_err and pkt_count show the new values, and they hold until the next completion.
- Back-to-back single-beat packets produce stat_valid pulses on consecutive cycles.
- **rst mid-packet:** the partial packet is discarded, no status is emitted, and rst overrides all other events in that cycle.
- **Stall tracking:** the previous-cycle copies of s_valid, s_ready and the payload fields are registered every cycle.

## Structure
- Package ss_pkg holds:
  - error bit index constants ERR_VALID_DROP=0, ERR_UNSTABLE=1, ERR_BAD_KEEP=2, ERR_OVERLEN=3;
  - LFSR_DEFAULT_SEED=16'hACE1;
  - the FSM state enum;
  - functions keep_popcount and keep_is_legal.
- One sub-module, ss_lfsr16, is instantiated for backpressure generation.

## Test plan
Defaults for all scenarios: NUM_BYTES=4, USER_BITS=1, MAX_PKT_BYTES=2048, LEN_W=16.
- bp_en=0; 3-beat packet, bytes 01..0A, last keep=4'b1100, user=1 → one stat_valid: stat_len=10, stat_csum=16'h0037, stat_user=1, stat_err=0, pkt_count=1.
- Master drops s_valid after 1 stall cycle, with bp_en=1 and seed 16'h0001 → stat_err=4'b0001 on the next completed packet; the following clean packet reports stat_err=0.
- Data changes while stalled → stat_err bit 1 set.
- Last keep=4'b1010 → stat_err=4'b0100. Last keep=4'b0000 → stat_err=4'b0100 and stat_len unchanged by that beat.
- 513 full beats → stat_len=2052, stat_err=4'b1000.
- Separate case: 100 back-to-back single-beat packets with bp_en=0 → 100 consecutive stat_valid pulses, pkt_count=100.
- rst asserted in the middle of beat 2 → no stat_valid; the next packet reports only its own length.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared definitions for ss streaming endpoints: error bit indices, LFSR seed,
// FSM states and keep-mask helpers.
package ss_pkg;

    localparam int unsigned ERR_W          = 4;
    localparam int unsigned ERR_VALID_DROP = 0;
    localparam int unsigned ERR_UNSTABLE   = 1;
    localparam int unsigned ERR_BAD_KEEP   = 2;
    localparam int unsigned ERR_OVERLEN    = 3;

    localparam int unsigned LFSR_W            = 16;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Keep masks are passed zero-extended to this width; n gives the real width.
    localparam int unsigned KEEP_MAX_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } ss_state_e;

    function automatic int unsigned keep_popcount(input logic [KEEP_MAX_W-1:0] keep,
                                                  input int unsigned           n);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
            if (i < n) begin
                cnt = cnt + 32'(keep[i]);
            end
        end
        return cnt;
    endfunction

    // Legal last-beat keep: non-zero and ones packed against the MSB of the n-bit field.
    function automatic logic keep_is_legal(input logic [KEEP_MAX_W-1:0] keep,
                                           input int unsigned           n);
        logic [KEEP_MAX_W-1:0] mask;
        logic [KEEP_MAX_W-1:0] inv;
        mask = '0;
        for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
            mask[i] = (i < n);
        end
        inv = ~keep & mask;
        return ((keep & mask) != '0) && ((inv & (inv + 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/ss_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11); exposes bit 0 of the next state
// so the owner can register it in lockstep with the LFSR itself.
module ss_lfsr16
    import ss_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed_i,
    output logic        next_bit_c_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign next_bit_c_o = lfsr_d[0];

    // An all-zero seed would lock the register, so substitute the default.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= (seed_i == 16'h0000) ? LFSR_DEFAULT_SEED : seed_i;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/ss_rx_checker.sv
// Terminal ss slave: optional LFSR backpressure, protocol rule checking and one
// status record per received packet.
module ss_rx_checker
    import ss_pkg::*;
#(
    parameter int unsigned NUM_BYTES     = 4,
    parameter int unsigned USER_BITS     = 1,
    parameter int unsigned MAX_PKT_BYTES = 2048,
    parameter int unsigned LEN_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [NUM_BYTES*8-1:0] s_data,
    input  logic [NUM_BYTES-1:0]   s_keep,
    input  logic                   s_last,
    input  logic [USER_BITS-1:0]   s_user,
    input  logic                   bp_en,
    input  logic [15:0]            bp_seed,
    output logic                   stat_valid,
    output logic [LEN_W-1:0]       stat_len,
    output logic [15:0]            stat_csum,
    output logic [USER_BITS-1:0]   stat_user,
    output logic [ERR_W-1:0]       stat_err,
    output logic [31:0]            pkt_count
);

    localparam int unsigned DATA_W = NUM_BYTES * 8;

    ss_state_e state_q, state_d;

    logic                 ready_q;
    logic                 lfsr_bit;
    logic                 prev_valid_q, prev_ready_q, prev_last_q;
    logic [DATA_W-1:0]    prev_data_q;
    logic [NUM_BYTES-1:0] prev_keep_q;
    logic [USER_BITS-1:0] prev_user_q;

    logic [LEN_W-1:0]     len_q, len_d;
    logic [15:0]          csum_q, csum_d;
    logic [USER_BITS-1:0] user_q, user_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 complete;

    logic                 stat_valid_q;
    logic [LEN_W-1:0]     stat_len_q;
    logic [15:0]          stat_csum_q;
    logic [USER_BITS-1:0] stat_user_q;
    logic [ERR_W-1:0]     stat_err_q;
    logic [31:0]          pkt_count_q;

    logic                 accept, first, stall_prev;
    logic [NUM_BYTES-1:0] eff_keep;
    logic [LEN_W-1:0]     beat_bytes, len_base, len_next;
    logic [LEN_W:0]       len_sum;
    logic [15:0]          csum_beat;
    logic [ERR_W-1:0]     viol, beat_err;

    ss_lfsr16 u_lfsr (
        .clk          (clk),
        .rst          (rst),
        .seed_i       (bp_seed),
        .next_bit_c_o (lfsr_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        accept     = s_valid & ready_q;
        first      = (state_q == ST_IDLE);
        stall_prev = prev_valid_q & ~prev_ready_q;

        // Stall-rule violations are judged every cycle, accepted or not.
        viol                 = '0;
        viol[ERR_VALID_DROP] = stall_prev & ~s_valid;
        viol[ERR_UNSTABLE]   = stall_prev & s_valid &
                               ((s_data != prev_data_q) | (s_keep != prev_keep_q) |
                                (s_last != prev_last_q) | (s_user != prev_user_q));

        eff_keep   = s_last ? s_keep : '1;
        beat_bytes = s_last ? LEN_W'(keep_popcount(KEEP_MAX_W'(s_keep), NUM_BYTES))
                            : LEN_W'(NUM_BYTES);
        len_base   = first ? '0 : len_q;
        len_sum    = {1'b0, len_base} + {1'b0, beat_bytes};
        len_next   = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

        csum_beat = '0;
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (eff_keep[b]) begin
                csum_beat = csum_beat + 16'(s_data[b*8 +: 8]);
            end
        end

        beat_err               = '0;
        beat_err[ERR_UNSTABLE] = ~first & (s_user != user_q);
        beat_err[ERR_BAD_KEEP] = s_last ? ~keep_is_legal(KEEP_MAX_W'(s_keep), NUM_BYTES)
                                        : (s_keep != '1);
        beat_err[ERR_OVERLEN]  = (32'(len_sum) > MAX_PKT_BYTES);

        state_d  = state_q;
        len_d    = len_q;
        csum_d   = csum_q;
        user_d   = user_q;
        err_d    = err_q | viol;
        complete = 1'b0;

        if (accept) begin
            len_d  = len_next;
            csum_d = (first ? 16'h0000 : csum_q) + csum_beat;
            user_d = first ? s_user : user_q;
            err_d  = err_q | viol | beat_err;
            if (s_last) begin
                state_d  = ST_IDLE;
                complete = 1'b1;
            end else begin
                state_d  = ST_BODY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q      <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_ready_q <= 1'b0;
            prev_last_q  <= 1'b0;
            prev_data_q  <= '0;
            prev_keep_q  <= '0;
            prev_user_q  <= '0;
            len_q        <= '0;
            csum_q       <= '0;
            user_q       <= '0;
            err_q        <= '0;
            stat_valid_q <= 1'b0;
            stat_len_q   <= '0;
            stat_csum_q  <= '0;
            stat_user_q  <= '0;
            stat_err_q   <= '0;
            pkt_count_q  <= '0;
        end else begin
            ready_q      <= bp_en ? lfsr_bit : 1'b1;
            prev_valid_q <= s_valid;
            prev_ready_q <= ready_q;
            prev_last_q  <= s_last;
            prev_data_q  <= s_data;
            prev_keep_q  <= s_keep;
            prev_user_q  <= s_user;
            len_q        <= len_d;
            csum_q       <= csum_d;
            user_q       <= user_d;
            // Violations seen while idle stay pending for the next packet.
            err_q        <= complete ? '0 : err_d;
            stat_valid_q <= complete;
            if (complete) begin
                stat_len_q  <= len_d;
                stat_csum_q <= csum_d;
                stat_user_q <= user_d;
                stat_err_q  <= err_d;
                pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end

    assign s_ready    = ready_q;
    assign stat_valid = stat_valid_q;
    assign stat_len   = stat_len_q;
    assign stat_csum  = stat_csum_q;
    assign stat_user  = stat_user_q;
    assign stat_err   = stat_err_q;
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_ss_rx_checker.sv
// Directed bench for ss_rx_checker: hand-computed status records checked with
// immediate assertions after each packet.
module tb_ss_rx_checker;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;
    logic [0:0]  s_user;
    logic        bp_en;
    logic [15:0] bp_seed;
    logic        stat_valid;
    logic [15:0] stat_len;
    logic [15:0] stat_csum;
    logic [0:0]  stat_user;
    logic [3:0]  stat_err;
    logic [31:0] pkt_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    ss_rx_checker #(
        .NUM_BYTES     (4),
        .USER_BITS     (1),
        .MAX_PKT_BYTES (2048),
        .LEN_W         (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_keep     (s_keep),
        .s_last     (s_last),
        .s_user     (s_user),
        .bp_en      (bp_en),
        .bp_seed    (bp_seed),
        .stat_valid (stat_valid),
        .stat_len   (stat_len),
        .stat_csum  (stat_csum),
        .stat_user  (stat_user),
        .stat_err   (stat_err),
        .pkt_count  (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic bp, input logic [15:0] seed);
        rst     = 1'b1;
        bp_en   = bp;
        bp_seed = seed;
        s_valid = 1'b0;
        s_data  = '0;
        s_keep  = '0;
        s_last  = 1'b0;
        s_user  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Presents one beat and returns just after the edge that accepts it.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        int waited;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_user  = u;
        waited  = 0;
        while (!s_ready && waited < 64) begin
            tick();
            waited++;
        end
        if (waited >= 64) check("ready_timeout", 32'(s_ready), 32'd1);
        tick();
    endtask

    task automatic check_stat(input string tag, input logic [15:0] len, input logic [15:0] csum,
                              input logic u, input logic [3:0] err, input logic [31:0] cnt);
        check({tag, "_valid"}, 32'(stat_valid), 32'd1);
        check({tag, "_len"},   32'(stat_len),   32'(len));
        check({tag, "_csum"},  32'(stat_csum),  32'(csum));
        check({tag, "_user"},  32'(stat_user),  32'(u));
        check({tag, "_err"},   32'(stat_err),   32'(err));
        check({tag, "_count"}, pkt_count,       cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset(1'b0, 16'h0000);
        check("rst_ready", 32'(s_ready),    32'd0);
        check("rst_valid", 32'(stat_valid), 32'd0);
        check("rst_len",   32'(stat_len),   32'd0);
        check("rst_csum",  32'(stat_csum),  32'd0);
        check("rst_user",  32'(stat_user),  32'd0);
        check("rst_err",   32'(stat_err),   32'd0);
        check("rst_count", pkt_count,       32'd0);
        tick();
        check("ready_after_rst", 32'(s_ready), 32'd1);

        // Three-beat packet, bytes 01..0A
        send(32'h01020304, 4'hF, 1'b0, 1'b1);
        send(32'h05060708, 4'hF, 1'b0, 1'b1);
        send(32'h090A0000, 4'b1100, 1'b1, 1'b1);
        s_valid = 1'b0;
        check_stat("pkt3", 16'd10, 16'h0037, 1'b1, 4'b0000, 32'd1);
        tick();
        check("pkt3_pulse_end", 32'(stat_valid), 32'd0);
        check("pkt3_len_hold",  32'(stat_len),   32'd10);

        // User changes on the second beat
        send(32'h00000001, 4'hF, 1'b0, 1'b1);
        send(32'h00000002, 4'hF, 1'b1, 1'b0);
        s_valid = 1'b0;
        check_stat("user_chg", 16'd8, 16'h0003, 1'b1, 4'b0010, 32'd2);

        // Non-contiguous last keep
        send(32'h11223344, 4'b1010, 1'b1, 1'b0);
        s_valid = 1'b0;
        check_stat("keep1010", 16'd2, 16'h0044, 1'b0, 4'b0100, 32'd3);

        // Zero last keep adds no bytes
        send(32'h01010101, 4'hF, 1'b0, 1'b0);
        send(32'hFFFFFFFF, 4'b0000, 1'b1, 1'b0);
        s_valid = 1'b0;
        check_stat("keep0000", 16'd4, 16'h0004, 1'b0, 4'b0100, 32'd4);

        // 513 full beats overrun the 2048-byte limit
        for (int i = 0; i < 512; i++) send(32'h01010101, 4'hF, 1'b0, 1'b0);
        send(32'h01010101, 4'hF, 1'b1, 1'b0);
        s_valid = 1'b0;
        check_stat("overlen", 16'd2052, 16'h0804, 1'b0, 4'b1000, 32'd5);

        // Zero seed falls back to ACE1, whose next bit 0 is 1
        do_reset(1'b1, 16'h0000);
        tick();
        check("seed0_ready", 32'(s_ready), 32'd1);

        // Valid dropped during a stall while idle
        do_reset(1'b1, 16'h0001);
        tick();
        check("seed1_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 32'h12345678;
        s_keep  = 4'hF;
        s_last  = 1'b1;
        s_user  = 1'b0;
        tick();
        s_valid = 1'b0;
        tick();
        bp_en = 1'b0;
        tick();
        send(32'h00000005, 4'hF, 1'b1, 1'b0);
        check_stat("drop", 16'd4, 16'h0005, 1'b0, 4'b0001, 32'd1);
        send(32'h00000006, 4'hF, 1'b1, 1'b0);
        s_valid = 1'b0;
        check_stat("after_drop", 16'd4, 16'h0006, 1'b0, 4'b0000, 32'd2);

        // Data changes while stalled
        do_reset(1'b1, 16'h0001);
        tick();
        s_valid = 1'b1;
        s_data  = 32'hA0A0A0A0;
        s_keep  = 4'hF;
        s_last  = 1'b1;
        s_user  = 1'b0;
        tick();
        s_data = 32'hB0B0B0B0;
        bp_en  = 1'b0;
        tick();
        send(32'hB0B0B0B0, 4'hF, 1'b1, 1'b0);
        s_valid = 1'b0;
        check_stat("unstable", 16'd4, 16'h02C0, 1'b0, 4'b0010, 32'd1);

        // 100 back-to-back single-beat packets
        do_reset(1'b0, 16'h0000);
        tick();
        s_valid = 1'b1;
        s_data  = 32'h00000001;
        s_keep  = 4'hF;
        s_last  = 1'b1;
        s_user  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("b2b_valid", 32'(stat_valid), 32'd1);
        end
        check("b2b_count", pkt_count, 32'd100);
        s_valid = 1'b0;
        tick();
        check("b2b_end", 32'(stat_valid), 32'd0);

        // Reset in the middle of beat 2
        send(32'h01020304, 4'hF, 1'b0, 1'b1);
        s_data = 32'h05060708;
        s_last = 1'b1;
        rst    = 1'b1;
        tick();
        check("midrst_valid", 32'(stat_valid), 32'd0);
        check("midrst_count", pkt_count,       32'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        tick();
        check("midrst_quiet", 32'(stat_valid), 32'd0);
        send(32'h0A0B0000, 4'b1100, 1'b1, 1'b0);
        s_valid = 1'b0;
        check_stat("post_rst", 16'd2, 16'h0015, 1'b0, 4'b0000, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
